// File: rtl/riscv_mem_port_arbiter.sv
// rtl/riscv_mem_port_arbiter.sv - fetch/data port arbiter in front of one single-port memory
`timescale 1ns/1ps
module riscv_mem_port_arbiter #(
  parameter int RD_LATENCY = 1,
  parameter int PRIO_DATA  = 1,
  parameter int MAX_WAIT   = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic        i_gnt_o,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [1:0]  d_size_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  output logic [1:0]  m_size_o,
  output logic        m_rd_o,
  output logic        m_wr_o,
  input  logic [31:0] m_rdata_i
);
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [3:0]            i_wait_q, i_wait_d, d_wait_q, d_wait_d;
  logic                  i_win, d_win, push_vld;
  logic [31:0]           m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic [1:0]            m_size_q, m_size_d;
  logic [RD_LATENCY-1:0] tag_vld_q, tag_port_q;
  logic                  head_vld, head_port;
  logic [31:0]           i_rdata_q, d_rdata_q;

  // The low-priority port only wins a contested cycle once it has waited MAX_WAIT cycles.
  always_comb begin
    i_win = 1'b0;
    d_win = 1'b0;
    if (reset_i) begin
      if (i_req_i && d_req_i) begin
        if (PRIO_DATA != 0) begin
          if (i_wait_q == WAIT_MAX) i_win = 1'b1;
          else                      d_win = 1'b1;
        end else begin
          if (d_wait_q == WAIT_MAX) d_win = 1'b1;
          else                      i_win = 1'b1;
        end
      end else begin
        i_win = i_req_i;
        d_win = d_req_i;
      end
    end
  end

  always_comb begin
    i_wait_d = '0;
    d_wait_d = '0;
    if (i_req_i && !i_win) i_wait_d = (i_wait_q == WAIT_MAX) ? WAIT_MAX : i_wait_q + 4'd1;
    if (d_req_i && !d_win) d_wait_d = (d_wait_q == WAIT_MAX) ? WAIT_MAX : d_wait_q + 4'd1;
  end

  always_comb begin
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_size_d  = m_size_q;
    m_rd_o    = 1'b0;
    m_wr_o    = 1'b0;
    if (i_win) begin
      m_addr_d  = i_addr_i;
      m_wdata_d = '0;
      m_size_d  = 2'd2;
      m_rd_o    = 1'b1;
    end else if (d_win) begin
      m_addr_d  = d_addr_i;
      m_wdata_d = d_wdata_i;
      m_size_d  = d_size_i;
      m_rd_o    = ~d_we_i;
      m_wr_o    = d_we_i;
    end
  end

  assign m_addr_o  = m_addr_d;
  assign m_wdata_o = m_wdata_d;
  assign m_size_o  = m_size_d;
  assign i_gnt_o   = i_win;
  assign d_gnt_o   = d_win;
  assign push_vld  = i_win | (d_win & ~d_we_i);

  // Tag port bit: 1 = data port. The oldest entry lines up with m_rdata_i.
  assign head_vld   = tag_vld_q[RD_LATENCY-1];
  assign head_port  = tag_port_q[RD_LATENCY-1];
  assign i_rvalid_o = head_vld & ~head_port;
  assign d_rvalid_o = head_vld & head_port;
  assign i_rdata_o  = i_rvalid_o ? m_rdata_i : i_rdata_q;
  assign d_rdata_o  = d_rvalid_o ? m_rdata_i : d_rdata_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      i_wait_q   <= '0;
      d_wait_q   <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_size_q   <= '0;
      tag_vld_q  <= '0;
      tag_port_q <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      i_wait_q      <= i_wait_d;
      d_wait_q      <= d_wait_d;
      m_addr_q      <= m_addr_d;
      m_wdata_q     <= m_wdata_d;
      m_size_q      <= m_size_d;
      tag_vld_q[0]  <= push_vld;
      tag_port_q[0] <= d_win;
      for (int j = 1; j < RD_LATENCY; j++) begin
        tag_vld_q[j]  <= tag_vld_q[j-1];
        tag_port_q[j] <= tag_port_q[j-1];
      end
      i_rdata_q <= i_rdata_o;
      d_rdata_q <= d_rdata_o;
    end
  end
endmodule

// File: tb/tb_riscv_mem_port_arbiter.sv
// tb/tb_riscv_mem_port_arbiter.sv - bench for riscv_mem_port_arbiter (two parameterisations)
`timescale 1ns/1ps
module tb_riscv_mem_port_arbiter;
  localparam int MAX_WAIT = 4;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        i_req[2], d_req[2], d_we[2];
  logic [31:0] i_addr[2], d_addr[2], d_wdata[2];
  logic [1:0]  d_size[2];
  logic        i_gnt[2], i_rvalid[2], d_gnt[2], d_rvalid[2], m_rd[2], m_wr[2];
  logic [31:0] i_rdata[2], d_rdata[2], m_addr[2], m_wdata[2], m_rdata[2];
  logic [1:0]  m_size[2];
  logic [135:0] outs[2];
  int checks = 0;
  int errors = 0;

  logic [31:0] mem[2][256];
  logic [31:0] dly[2][4];

  // Instance 0: data priority, latency 1. Instance 1: fetch priority, latency 3.
  riscv_mem_port_arbiter #(.RD_LATENCY(LAT0), .PRIO_DATA(1), .MAX_WAIT(MAX_WAIT)) u0 (
    .clk_i(clk), .reset_i(rst_n),
    .i_req_i(i_req[0]), .i_addr_i(i_addr[0]), .i_gnt_o(i_gnt[0]), .i_rvalid_o(i_rvalid[0]), .i_rdata_o(i_rdata[0]),
    .d_req_i(d_req[0]), .d_we_i(d_we[0]), .d_addr_i(d_addr[0]), .d_wdata_i(d_wdata[0]), .d_size_i(d_size[0]),
    .d_gnt_o(d_gnt[0]), .d_rvalid_o(d_rvalid[0]), .d_rdata_o(d_rdata[0]),
    .m_addr_o(m_addr[0]), .m_wdata_o(m_wdata[0]), .m_size_o(m_size[0]), .m_rd_o(m_rd[0]), .m_wr_o(m_wr[0]),
    .m_rdata_i(m_rdata[0]));

  riscv_mem_port_arbiter #(.RD_LATENCY(LAT1), .PRIO_DATA(0), .MAX_WAIT(MAX_WAIT)) u1 (
    .clk_i(clk), .reset_i(rst_n),
    .i_req_i(i_req[1]), .i_addr_i(i_addr[1]), .i_gnt_o(i_gnt[1]), .i_rvalid_o(i_rvalid[1]), .i_rdata_o(i_rdata[1]),
    .d_req_i(d_req[1]), .d_we_i(d_we[1]), .d_addr_i(d_addr[1]), .d_wdata_i(d_wdata[1]), .d_size_i(d_size[1]),
    .d_gnt_o(d_gnt[1]), .d_rvalid_o(d_rvalid[1]), .d_rdata_o(d_rdata[1]),
    .m_addr_o(m_addr[1]), .m_wdata_o(m_wdata[1]), .m_size_o(m_size[1]), .m_rd_o(m_rd[1]), .m_wr_o(m_wr[1]),
    .m_rdata_i(m_rdata[1]));

  assign outs[0] = {i_gnt[0], d_gnt[0], i_rvalid[0], d_rvalid[0], m_rd[0], m_wr[0],
                    i_rdata[0], d_rdata[0], m_addr[0], m_wdata[0], m_size[0]};
  assign outs[1] = {i_gnt[1], d_gnt[1], i_rvalid[1], d_rvalid[1], m_rd[1], m_wr[1],
                    i_rdata[1], d_rdata[1], m_addr[1], m_wdata[1], m_size[1]};
  assign m_rdata[0] = dly[0][LAT0-1];
  assign m_rdata[1] = dly[1][LAT1-1];

  // Memory with fixed read latency; unused cycles return random junk on m_rdata.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_wr[k]) begin
        case (m_size[k])
          2'd0:    mem[k][m_addr[k][9:2]][{m_addr[k][1:0], 3'b000} +: 8] <= m_wdata[k][7:0];
          2'd1:    mem[k][m_addr[k][9:2]][{m_addr[k][1], 4'b0000} +: 16] <= m_wdata[k][15:0];
          default: mem[k][m_addr[k][9:2]] <= m_wdata[k];
        endcase
      end
      for (int j = 3; j > 0; j--) dly[k][j] <= dly[k][j-1];
      dly[k][0] <= m_rd[k] ? mem[k][m_addr[k][9:2]] : $urandom;
    end
  end

  // Reference model state
  int          mdl_cnt[2], mdl_cyc[2];
  logic [31:0] mdl_addr[2], mdl_wdata[2], mdl_hold_i[2], mdl_hold_d[2];
  logic [1:0]  mdl_size[2];
  logic        sb_v[2][8], sb_p[2][8];
  logic [31:0] sb_dat[2][8];

  task automatic run_model();
    logic ei, ed, erd, ewr, eiv, edv, lo_req, lo_gnt, forced;
    logic [31:0] eaddr, ewd;
    logic [1:0] esz;
    int slot, lat;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        lat = (k == 0) ? LAT0 : LAT1;
        if (!rst_n) begin
          checks++;
          if (outs[k] !== '0) begin
            errors++;
            $display("FAIL model_reset_outputs[%0d]: got %h expected 0", k, outs[k]);
          end
          mdl_cnt[k] = 0; mdl_cyc[k] = 0;
          mdl_addr[k] = '0; mdl_wdata[k] = '0; mdl_size[k] = '0;
          mdl_hold_i[k] = '0; mdl_hold_d[k] = '0;
          for (int s = 0; s < 8; s++) sb_v[k][s] = 1'b0;
        end else begin
          forced = 1'b0;
          if (i_req[k] && d_req[k]) begin
            forced = (mdl_cnt[k] == MAX_WAIT);
            ed = (k == 0) ? !forced : forced;
            ei = !ed;
          end else begin
            ei = i_req[k];
            ed = d_req[k];
          end
          checks++;
          if ({i_gnt[k], d_gnt[k]} !== {ei, ed}) begin
            errors++;
            $display("FAIL model_grant[%0d] cyc %0d: got i=%b d=%b expected i=%b d=%b", k, mdl_cyc[k], i_gnt[k], d_gnt[k], ei, ed);
          end
          if (ei) begin
            erd = 1'b1; ewr = 1'b0; eaddr = i_addr[k]; esz = 2'd2; ewd = '0;
          end else if (ed) begin
            erd = !d_we[k]; ewr = d_we[k]; eaddr = d_addr[k]; esz = d_size[k]; ewd = d_wdata[k];
          end else begin
            erd = 1'b0; ewr = 1'b0; eaddr = mdl_addr[k]; esz = mdl_size[k]; ewd = mdl_wdata[k];
          end
          checks++;
          if ({m_rd[k], m_wr[k], m_addr[k], m_size[k], m_wdata[k]} !== {erd, ewr, eaddr, esz, ewd}) begin
            errors++;
            $display("FAIL model_mem_drive[%0d]: got rd=%b wr=%b a=%h s=%0d w=%h expected rd=%b wr=%b a=%h s=%0d w=%h",
                     k, m_rd[k], m_wr[k], m_addr[k], m_size[k], m_wdata[k], erd, ewr, eaddr, esz, ewd);
          end
          mdl_addr[k] = eaddr; mdl_size[k] = esz; mdl_wdata[k] = ewd;
          slot = mdl_cyc[k] % 8;
          eiv = sb_v[k][slot] && !sb_p[k][slot];
          edv = sb_v[k][slot] && sb_p[k][slot];
          if (eiv) mdl_hold_i[k] = sb_dat[k][slot];
          if (edv) mdl_hold_d[k] = sb_dat[k][slot];
          sb_v[k][slot] = 1'b0;
          checks++;
          if ({i_rvalid[k], d_rvalid[k], i_rdata[k], d_rdata[k]} !== {eiv, edv, mdl_hold_i[k], mdl_hold_d[k]}) begin
            errors++;
            $display("FAIL model_response[%0d]: got iv=%b dv=%b id=%h dd=%h expected iv=%b dv=%b id=%h dd=%h",
                     k, i_rvalid[k], d_rvalid[k], i_rdata[k], d_rdata[k], eiv, edv, mdl_hold_i[k], mdl_hold_d[k]);
          end
          if (erd) begin
            slot = (mdl_cyc[k] + lat) % 8;
            sb_v[k][slot] = 1'b1;
            sb_p[k][slot] = ed;
            sb_dat[k][slot] = mem[k][eaddr[9:2]];
          end
          lo_req = (k == 0) ? i_req[k] : d_req[k];
          lo_gnt = (k == 0) ? ei : ed;
          if (lo_req && !lo_gnt) begin
            if (mdl_cnt[k] < MAX_WAIT) mdl_cnt[k]++;
          end else begin
            mdl_cnt[k] = 0;
          end
          mdl_cyc[k]++;
        end
      end
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b0; i_addr[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0; d_size[k] = 2'd2;
    end
  endtask

  task automatic test_reset();
    i_req[0] = 1'b1; i_addr[0] = 32'h10; d_req[0] = 1'b1; d_addr[0] = 32'h14;
    i_req[1] = 1'b1; d_req[1] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (outs[k] !== '0) begin errors++; $display("FAIL reset_held[%0d]: got %h expected 0", k, outs[k]); end
      end
    end
    @(posedge clk); #1;
    idle_all();
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (outs[k] !== '0) begin errors++; $display("FAIL reset_release_idle[%0d]: got %h expected 0", k, outs[k]); end
      end
    end
    @(posedge clk); #1;
    d_req[1] = 1'b1; d_addr[1] = 32'h80;
    @(negedge clk);
    checks++;
    if (d_gnt[1] !== 1'b1) begin errors++; $display("FAIL reset_inflight_gnt: got %b expected 1", d_gnt[1]); end
    @(posedge clk); #1;
    d_req[1] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({i_rvalid[k], d_rvalid[k]} !== 2'b00) begin
          errors++; $display("FAIL reset_inflight_rvalid[%0d]: got %b%b expected 00", k, i_rvalid[k], d_rvalid[k]);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_fetch();
    mem[0][64] <= 32'h00500093;
    i_req[0] = 1'b1; i_addr[0] = 32'h100;
    @(negedge clk);
    checks++;
    if (i_gnt[0] !== 1'b1) begin errors++; $display("FAIL fetch_gnt: got %b expected 1", i_gnt[0]); end
    checks++;
    if ({m_rd[0], m_addr[0]} !== {1'b1, 32'h100}) begin
      errors++; $display("FAIL fetch_mem: got rd=%b addr=%h expected rd=1 addr=00000100", m_rd[0], m_addr[0]);
    end
    @(posedge clk); #1;
    i_req[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({i_rvalid[0], i_rdata[0]} !== {1'b1, 32'h00500093}) begin
      errors++; $display("FAIL fetch_data: got v=%b d=%h expected v=1 d=00500093", i_rvalid[0], i_rdata[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    logic gi, gd;
    i_req[0] = 1'b1; i_addr[0] = 32'h300;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_size[0] = 2'd2; d_addr[0] = 32'h200;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({i_gnt[0], d_gnt[0]} !== {c % 5 == 4, c % 5 != 4}) begin
        errors++; $display("FAIL contention_grant c=%0d: got i=%b d=%b expected i=%b", c, i_gnt[0], d_gnt[0], c % 5 == 4);
      end
      if (c > 0) begin
        checks++;
        if ({i_rvalid[0], d_rvalid[0]} !== {(c - 1) % 5 == 4, (c - 1) % 5 != 4}) begin
          errors++; $display("FAIL contention_tag c=%0d: got iv=%b dv=%b", c, i_rvalid[0], d_rvalid[0]);
        end
      end
      gi = i_gnt[0]; gd = d_gnt[0];
      @(posedge clk); #1;
      if (gi) i_addr[0] = i_addr[0] + 32'd4;
      if (gd) d_addr[0] = d_addr[0] + 32'd4;
    end
    idle_all();
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h204; d_wdata[0] = 32'hDEADBEEF; d_size[0] = 2'd2;
    @(negedge clk);
    checks++;
    if ({d_gnt[0], m_wr[0], m_rd[0]} !== 3'b110) begin
      errors++; $display("FAIL write_strobe: got gnt=%b wr=%b rd=%b expected 1 1 0", d_gnt[0], m_wr[0], m_rd[0]);
    end
    @(posedge clk); #1;
    d_req[0] = 1'b0; d_we[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (d_rvalid[0] !== 1'b0) begin errors++; $display("FAIL write_no_rvalid: got %b expected 0", d_rvalid[0]); end
    @(posedge clk); #1;
    d_req[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (d_gnt[0] !== 1'b1) begin errors++; $display("FAIL readback_gnt: got %b expected 1", d_gnt[0]); end
    @(posedge clk); #1;
    d_req[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_rvalid[0], d_rdata[0]} !== {1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL readback_data: got v=%b d=%h expected v=1 d=deadbeef", d_rvalid[0], d_rdata[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ei, edd;
    mem[1][10] <= 32'hA0A0_0001;
    mem[1][11] <= 32'hB0B0_0002;
    mem[1][12] <= 32'hC0C0_0003;
    @(posedge clk); #1;
    for (int c = 1; c <= 7; c++) begin
      i_req[1] = (c == 1) || (c == 3);
      i_addr[1] = (c == 1) ? 32'h28 : 32'h30;
      d_req[1] = (c == 2); d_we[1] = 1'b0; d_addr[1] = 32'h2C; d_size[1] = 2'd2;
      @(negedge clk);
      checks++;
      if ({i_gnt[1], d_gnt[1]} !== {(c == 1) || (c == 3), c == 2}) begin
        errors++; $display("FAIL b2b_grant c=%0d: got i=%b d=%b", c, i_gnt[1], d_gnt[1]);
      end
      checks++;
      if ({i_rvalid[1], d_rvalid[1]} !== {(c == 4) || (c == 6), c == 5}) begin
        errors++; $display("FAIL b2b_rvalid c=%0d: got iv=%b dv=%b", c, i_rvalid[1], d_rvalid[1]);
      end
      ei  = (c < 4) ? 32'h0 : (c < 6) ? 32'hA0A0_0001 : 32'hC0C0_0003;
      edd = (c < 5) ? 32'h0 : 32'hB0B0_0002;
      checks++;
      if ({i_rdata[1], d_rdata[1]} !== {ei, edd}) begin
        errors++; $display("FAIL b2b_rdata c=%0d: got i=%h d=%h expected i=%h d=%h", c, i_rdata[1], d_rdata[1], ei, edd);
      end
      @(posedge clk); #1;
    end
    idle_all();
  endtask

  task automatic test_prio_instr();
    i_req[1] = 1'b1; i_addr[1] = 32'h40;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h44; d_size[1] = 2'd2;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({i_gnt[1], d_gnt[1]} !== {c != 4, c == 4}) begin
        errors++; $display("FAIL prio_instr c=%0d: got i=%b d=%b expected d=%b", c, i_gnt[1], d_gnt[1], c == 4);
      end
      @(posedge clk); #1;
    end
    i_req[1] = 1'b0; d_req[1] = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 8; c++) begin
      i_req[1] = 1'b1;
      d_req[1] = (c != 2);
      @(negedge clk);
      checks++;
      if ({i_gnt[1], d_gnt[1]} !== {c != 7, c == 7}) begin
        errors++; $display("FAIL prio_wait_clear c=%0d: got i=%b d=%b expected d=%b", c, i_gnt[1], d_gnt[1], c == 7);
      end
      @(posedge clk); #1;
    end
    idle_all();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_random(input int n);
    logic gi[2], gd[2];
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin gi[k] = i_gnt[k]; gd[k] = d_gnt[k]; end
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (!i_req[k] || gi[k]) begin
          i_req[k] = ($urandom_range(0, 3) != 0);
          i_addr[k] = {22'd0, 8'($urandom), 2'b00};
        end
        if (!d_req[k] || gd[k]) begin
          d_req[k] = ($urandom_range(0, 3) != 0);
          d_we[k] = ($urandom_range(0, 2) == 0);
          d_size[k] = 2'($urandom_range(0, 2));
          d_addr[k] = {22'd0, 8'($urandom), 2'($urandom)};
          if (d_size[k] == 2'd1) d_addr[k][0] = 1'b0;
          if (d_size[k] == 2'd2) d_addr[k][1:0] = 2'b00;
          d_wdata[k] = $urandom;
        end
      end
    end
    idle_all();
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) mem[k][i] <= $urandom;
      for (int j = 0; j < 4; j++) dly[k][j] <= '0;
    end
    idle_all();
    rst_n = 1'b0;
    fork
      run_model();
    join_none
    test_reset();
    test_single_fetch();
    test_contention();
    test_write_read();
    test_back_to_back();
    test_prio_instr();
    test_random(600);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
